// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive path.
package usb_rx_pkg;

  localparam logic USB_J_LEVEL           = 1'b1;
  localparam int   USB_STUFF_LEN_DEFAULT = 6;

  typedef logic [7:0] rx_word_t;

  typedef enum logic [1:0] {
    BIT_DATA,
    BIT_STUFF,
    BIT_EOP
  } rx_bit_kind_e;

endpackage

// File: rtl/usb_rx_deser.sv
// LSB-first deserialiser: shift register, bit counter and completed-word register.
// Exposes bit_cnt only when USB_NRZI_ALIGN_CHECK_EN is defined.
module usb_rx_deser #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              flush,
  input  logic              bit_valid,
  input  logic              bit_data,
`ifdef USB_NRZI_ALIGN_CHECK_EN
  output logic [$clog2(DATA_W)-1:0] bit_cnt,
`endif
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid
);

  localparam int              CW   = $clog2(DATA_W);
  localparam logic [CW-1:0]   LAST = CW'(DATA_W - 1);

  logic [DATA_W-1:0] shreg_reg, shreg_next;
  logic [CW-1:0]     bit_cnt_reg, bit_cnt_next;
  logic [DATA_W-1:0] data_out_reg, data_out_next;
  logic              data_valid_reg, data_valid_next;

  always_comb begin
    shreg_next      = shreg_reg;
    bit_cnt_next    = bit_cnt_reg;
    data_out_next   = data_out_reg;
    data_valid_next = 1'b0;
    if (flush) begin
      shreg_next   = '0;
      bit_cnt_next = '0;
    end else if (bit_valid) begin
      // New bits enter at the MSB so the first bit ends up at the LSB.
      shreg_next = {bit_data, shreg_reg[DATA_W-1:1]};
      if (bit_cnt_reg == LAST) begin
        data_out_next   = shreg_next;
        data_valid_next = 1'b1;
        bit_cnt_next    = '0;
      end else begin
        bit_cnt_next = bit_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_reg      <= '0;
      bit_cnt_reg    <= '0;
      data_out_reg   <= '0;
      data_valid_reg <= 1'b0;
    end else if (clear) begin
      shreg_reg      <= '0;
      bit_cnt_reg    <= '0;
      data_out_reg   <= '0;
      data_valid_reg <= 1'b0;
    end else begin
      shreg_reg      <= shreg_next;
      bit_cnt_reg    <= bit_cnt_next;
      data_out_reg   <= data_out_next;
      data_valid_reg <= data_valid_next;
    end
  end

`ifdef USB_NRZI_ALIGN_CHECK_EN
  assign bit_cnt = bit_cnt_reg;
`endif
  assign data_out   = data_out_reg;
  assign data_valid = data_valid_reg;

endmodule

// File: rtl/usb_nrzi_rx_decoder.sv
// USB receive NRZI decoder with bit unstuffing and word deserialisation.
// Define USB_NRZI_ALIGN_CHECK_EN to flag packet ends that are not word aligned.
module usb_nrzi_rx_decoder
  import usb_rx_pkg::*;
#(
  parameter int   DATA_W     = 8,
  parameter int   STUFF_LEN  = USB_STUFF_LEN_DEFAULT,
  parameter logic IDLE_LEVEL = USB_J_LEVEL
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dplus_in,
  input  logic              shift_enable,
  input  logic              eop,
  input  logic              clear,
  output logic              d_sent,
  output logic              bit_valid,
  output logic              bit_data,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              stuff_err,
  output logic              align_err
);

  localparam int OW = $clog2(STUFF_LEN + 1);

  logic          line_q_reg;
  logic          prev_level_reg, prev_level_next;
  logic [OW-1:0] ones_cnt_reg, ones_cnt_next;
  logic          bit_valid_reg, bit_valid_next;
  logic          bit_data_reg, bit_data_next;
  logic          stuff_err_reg, stuff_err_next;
  logic          flush;
  rx_bit_kind_e  kind;

  assign d_sent = ~(prev_level_reg ^ line_q_reg);

  always_comb begin
    if (eop)
      kind = BIT_EOP;
    else if (ones_cnt_reg == OW'(STUFF_LEN))
      kind = BIT_STUFF;
    else
      kind = BIT_DATA;
  end

  always_comb begin
    prev_level_next = prev_level_reg;
    ones_cnt_next   = ones_cnt_reg;
    bit_valid_next  = 1'b0;
    bit_data_next   = 1'b0;
    stuff_err_next  = 1'b0;
    flush           = 1'b0;
    if (shift_enable) begin
      case (kind)
        BIT_EOP: begin
          prev_level_next = IDLE_LEVEL;
          ones_cnt_next   = '0;
          flush           = 1'b1;
        end
        BIT_STUFF: begin
          // A 1 where a stuff bit belongs means the run was never broken.
          prev_level_next = line_q_reg;
          ones_cnt_next   = '0;
          if (d_sent) begin
            stuff_err_next = 1'b1;
            flush          = 1'b1;
          end
        end
        default: begin
          prev_level_next = line_q_reg;
          ones_cnt_next   = d_sent ? ones_cnt_reg + 1'b1 : '0;
          bit_valid_next  = 1'b1;
          bit_data_next   = d_sent;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      line_q_reg <= IDLE_LEVEL;
    else
      line_q_reg <= dplus_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_level_reg <= IDLE_LEVEL;
      ones_cnt_reg   <= '0;
      bit_valid_reg  <= 1'b0;
      bit_data_reg   <= 1'b0;
      stuff_err_reg  <= 1'b0;
    end else if (clear) begin
      prev_level_reg <= IDLE_LEVEL;
      ones_cnt_reg   <= '0;
      bit_valid_reg  <= 1'b0;
      bit_data_reg   <= 1'b0;
      stuff_err_reg  <= 1'b0;
    end else begin
      prev_level_reg <= prev_level_next;
      ones_cnt_reg   <= ones_cnt_next;
      bit_valid_reg  <= bit_valid_next;
      bit_data_reg   <= bit_data_next;
      stuff_err_reg  <= stuff_err_next;
    end
  end

`ifdef USB_NRZI_ALIGN_CHECK_EN
  logic [$clog2(DATA_W)-1:0] bit_cnt;
  logic                      align_err_reg, align_err_next;

  assign align_err_next = shift_enable && eop && (bit_cnt != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      align_err_reg <= 1'b0;
    else if (clear)
      align_err_reg <= 1'b0;
    else
      align_err_reg <= align_err_next;
  end

  assign align_err = align_err_reg;
`else
  assign align_err = 1'b0;
`endif

  usb_rx_deser #(
    .DATA_W(DATA_W)
  ) u_deser (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .flush     (flush),
    .bit_valid (bit_valid_next),
    .bit_data  (bit_data_next),
`ifdef USB_NRZI_ALIGN_CHECK_EN
    .bit_cnt   (bit_cnt),
`endif
    .data_out  (data_out),
    .data_valid(data_valid)
  );

  assign bit_valid = bit_valid_reg;
  assign bit_data  = bit_data_reg;
  assign stuff_err = stuff_err_reg;

endmodule

// File: tb/tb_usb_nrzi_rx_decoder.sv
// Directed self-checking bench for usb_nrzi_rx_decoder (default parameters).
module tb_usb_nrzi_rx_decoder;
  import usb_rx_pkg::*;

  logic     clk = 1'b0;
  logic     rst = 1'b1;
  logic     dplus_in = 1'b1;
  logic     shift_enable = 1'b0;
  logic     eop = 1'b0;
  logic     clear = 1'b0;
  logic     d_sent, bit_valid, bit_data, data_valid, stuff_err, align_err;
  rx_word_t data_out;

  int checks = 0;
  int errors = 0;

  int bv_total = 0;
  int dv_total = 0;
  int se_total = 0;
  int ae_total = 0;
  rx_word_t words[$];

`ifdef USB_NRZI_ALIGN_CHECK_EN
  localparam logic ALIGN_EXP = 1'b1;
`else
  localparam logic ALIGN_EXP = 1'b0;
`endif

  usb_nrzi_rx_decoder dut (
    .clk         (clk),
    .rst         (rst),
    .dplus_in    (dplus_in),
    .shift_enable(shift_enable),
    .eop         (eop),
    .clear       (clear),
    .d_sent      (d_sent),
    .bit_valid   (bit_valid),
    .bit_data    (bit_data),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .stuff_err   (stuff_err),
    .align_err   (align_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bit_valid)  bv_total++;
    if (stuff_err)  se_total++;
    if (align_err)  ae_total++;
    if (data_valid) begin
      dv_total++;
      words.push_back(data_out);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a line level, let the sampler capture it, then strobe it.
  task automatic send_level(input logic lvl);
    dplus_in = lvl;
    step();
    shift_enable = 1'b1;
    step();
    shift_enable = 1'b0;
  endtask

  task automatic do_clear();
    dplus_in = 1'b1;
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    step();
  endtask

  task automatic test_reset();
    logic [7:0] lv;
    lv = 8'b0001_0101;
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({bit_valid, data_valid, stuff_err, align_err, data_out, d_sent} !== {4'b0000, 8'h00, 1'b1}) begin
      errors++;
      $display("FAIL reset_init: outs=%b data_out=%h d_sent=%b, required 0000/00/1",
               {bit_valid, data_valid, stuff_err, align_err}, data_out, d_sent);
    end
    rst = 1'b0;
    step();
    for (int i = 0; i < 5; i++) send_level(lv[i]);
    checks++;
    if (dut.u_deser.bit_cnt_reg !== 3'd5) begin
      errors++;
      $display("FAIL reset_midword_cnt: bit_cnt=%0d required 5", dut.u_deser.bit_cnt_reg);
    end
    dplus_in = 1'b1;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bit_valid, bit_data, data_valid, stuff_err, align_err, data_out} !== 13'd0) begin
      errors++;
      $display("FAIL reset_async_outs: bv=%b bd=%b dv=%b se=%b ae=%b do=%h required all 0",
               bit_valid, bit_data, data_valid, stuff_err, align_err, data_out);
    end
    checks++;
    if (d_sent !== 1'b1) begin
      errors++;
      $display("FAIL reset_d_sent: got %b required 1", d_sent);
    end
    checks++;
    if (dut.u_deser.bit_cnt_reg !== 3'd0) begin
      errors++;
      $display("FAIL reset_bit_cnt: got %0d required 0", dut.u_deser.bit_cnt_reg);
    end
    step();
    rst = 1'b0;
    step();
    begin
      int dv0 = dv_total;
      lv = 8'b1100_1001;
      for (int i = 0; i < 8; i++) send_level(lv[i]);
      step();
      checks++;
      if (dv_total - dv0 !== 1 || words[words.size()-1] !== 8'hA5) begin
        errors++;
        $display("FAIL reset_next_word: dv=%0d word=%h required 1/a5",
                 dv_total - dv0, words[words.size()-1]);
      end
    end
    $display("test_reset done: errors=%0d", errors);
  endtask

  task automatic test_word_decode();
    logic [7:0] lv;
    int bv0, dv0;
    lv = 8'b1100_1001;
    do_clear();
    bv0 = bv_total;
    dv0 = dv_total;
    for (int i = 0; i < 8; i++) begin
      send_level(lv[i]);
      checks++;
      if (data_valid !== (i == 7)) begin
        errors++;
        $display("FAIL word_dv_timing: bit %0d data_valid=%b required %b", i, data_valid, i == 7);
      end
    end
    checks++;
    if (data_out !== 8'hA5) begin
      errors++;
      $display("FAIL word_data_out: got %h required a5", data_out);
    end
    step();
    step();
    checks++;
    if (bv_total - bv0 !== 8 || dv_total - dv0 !== 1) begin
      errors++;
      $display("FAIL word_counts: bv=%0d dv=%0d required 8/1", bv_total - bv0, dv_total - dv0);
    end
    $display("test_word_decode done: data_out=%h", data_out);
  endtask

  task automatic test_stuff_drop();
    int bv0, se0;
    do_clear();
    bv0 = bv_total;
    se0 = se_total;
    for (int i = 0; i < 6; i++) send_level(1'b1);
    send_level(1'b0);
    checks++;
    if (bit_valid !== 1'b0) begin
      errors++;
      $display("FAIL stuff_drop_pulse: bit_valid=%b on stuff period, required 0", bit_valid);
    end
    step();
    step();
    checks++;
    if (bv_total - bv0 !== 6 || se_total - se0 !== 0) begin
      errors++;
      $display("FAIL stuff_drop_counts: bv=%0d se=%0d required 6/0", bv_total - bv0, se_total - se0);
    end
    checks++;
    if (dut.u_deser.bit_cnt_reg !== 3'd6) begin
      errors++;
      $display("FAIL stuff_drop_bit_cnt: got %0d required 6", dut.u_deser.bit_cnt_reg);
    end
    $display("test_stuff_drop done: bit_cnt=%0d", dut.u_deser.bit_cnt_reg);
  endtask

  task automatic test_stuff_error();
    logic [7:0] lv;
    int se0, dv0, n0;
    do_clear();
    se0 = se_total;
    dv0 = dv_total;
    for (int i = 0; i < 7; i++) send_level(1'b1);
    checks++;
    if (stuff_err !== 1'b1) begin
      errors++;
      $display("FAIL stuff_err_pulse: got %b required 1", stuff_err);
    end
    step();
    step();
    checks++;
    if (se_total - se0 !== 1 || dv_total - dv0 !== 0) begin
      errors++;
      $display("FAIL stuff_err_counts: se=%0d dv=%0d required 1/0", se_total - se0, dv_total - dv0);
    end
    n0 = words.size();
    lv = 8'b1100_1001;
    for (int i = 0; i < 8; i++) send_level(lv[i]);
    step();
    step();
    checks++;
    if (words.size() - n0 !== 1 || words[words.size()-1] !== 8'hA5) begin
      errors++;
      $display("FAIL stuff_err_next_word: words=%0d last=%h required 1/a5",
               words.size() - n0, words[words.size()-1]);
    end
    $display("test_stuff_error done: stuff_err count=%0d", se_total - se0);
  endtask

  task automatic test_eop_clear();
    int dv0, bv0;
    do_clear();
    dv0 = dv_total;
    for (int i = 0; i < 3; i++) send_level(1'b0);
    dplus_in = 1'b0;
    step();
    eop = 1'b1;
    shift_enable = 1'b1;
    step();
    eop = 1'b0;
    shift_enable = 1'b0;
    checks++;
    if (align_err !== ALIGN_EXP || bit_valid !== 1'b0) begin
      errors++;
      $display("FAIL eop_align: align_err=%b bit_valid=%b required %b/0", align_err, bit_valid, ALIGN_EXP);
    end
    checks++;
    if (dut.prev_level_reg !== 1'b1 || dut.u_deser.bit_cnt_reg !== 3'd0) begin
      errors++;
      $display("FAIL eop_state: prev_level=%b bit_cnt=%0d required 1/0",
               dut.prev_level_reg, dut.u_deser.bit_cnt_reg);
    end
    step();
    step();
    checks++;
    if (dv_total - dv0 !== 0) begin
      errors++;
      $display("FAIL eop_no_dv: dv=%0d required 0", dv_total - dv0);
    end
    bv0 = bv_total;
    dplus_in = 1'b1;
    step();
    clear = 1'b1;
    shift_enable = 1'b1;
    step();
    clear = 1'b0;
    shift_enable = 1'b0;
    step();
    checks++;
    if (bv_total - bv0 !== 0) begin
      errors++;
      $display("FAIL clear_with_strobe: bv=%0d required 0", bv_total - bv0);
    end
    $display("test_eop_clear done: align_err expected %b", ALIGN_EXP);
  endtask

  task automatic test_back_to_back();
    logic [16:0] lv;
    int dv0, bv0, se0, n0;
    // 0x00 as toggles from J, then 0xFF as six holds, one stuff toggle, two holds.
    lv = 17'b00_0_111111_10101010;
    do_clear();
    dv0 = dv_total;
    bv0 = bv_total;
    se0 = se_total;
    n0 = words.size();
    for (int k = 0; k < 17; k++) begin
      dplus_in = lv[k];
      shift_enable = (k > 0);
      step();
    end
    step();
    shift_enable = 1'b0;
    step();
    step();
    checks++;
    if (dv_total - dv0 !== 2 || bv_total - bv0 !== 16 || se_total - se0 !== 0) begin
      errors++;
      $display("FAIL b2b_counts: dv=%0d bv=%0d se=%0d required 2/16/0",
               dv_total - dv0, bv_total - bv0, se_total - se0);
    end
    checks++;
    if (words.size() - n0 !== 2 || words[n0] !== 8'h00 || words[n0+1] !== 8'hFF) begin
      errors++;
      $display("FAIL b2b_words: n=%0d first=%h second=%h required 2/00/ff",
               words.size() - n0, words[n0], words[n0+1]);
    end
    $display("test_back_to_back done: words=%0d", words.size() - n0);
  endtask

  initial begin
    test_reset();
    test_word_decode();
    test_stuff_drop();
    test_stuff_error();
    test_eop_clear();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, required completion");
    $fatal(1);
  end

endmodule
